// File: rtl/instruction_decode_if.sv
// ID-stage bundle: fetch inputs, pipeline controls, write-back port and ID/EX outputs.
// The decoder takes the slave side; fetch/control/write-back logic takes the master side.
interface instruction_decode_if #(
   parameter int XLEN = 64
);
   logic [XLEN-1:0] if_pc;
   logic [31:0]     if_instr;
   logic            if_valid;
   logic            stall;
   logic            flush;
   logic            wb_en;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;

   logic            id_valid;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [XLEN-1:0] imm;
   logic [4:0]      rd;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [2:0]      funct3;
   logic            funct7b5;
   logic            reg_write;
   logic            mem_read;
   logic            mem_write;
   logic            mem_to_reg;
   logic            alu_src;
   logic            branch;
   logic            jump;
   logic [1:0]      alu_op;
   logic            illegal;

   modport master (
      output if_pc, if_instr, if_valid, stall, flush, wb_en, wb_rd, wb_data,
      input  id_valid, id_pc, rs1_data, rs2_data, imm, rd, rs1, rs2, funct3, funct7b5,
             reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump, alu_op, illegal
   );

   modport slave (
      input  if_pc, if_instr, if_valid, stall, flush, wb_en, wb_rd, wb_data,
      output id_valid, id_pc, rs1_data, rs2_data, imm, rd, rs1, rs2, funct3, funct7b5,
             reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump, alu_op, illegal
   );
endinterface

// File: rtl/instruction_decode.sv
// RV64I decode stage: register file, immediate/control generation and ID/EX register.
// Define WB_BYPASS_EN to forward same-cycle write-back data onto the operand reads.
module instruction_decode #(
   parameter int XLEN     = 64,
   parameter int NUM_REGS = 32
) (
   input logic               clk,
   input logic               reset,
   instruction_decode_if.slave bus
);

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic       branch;
      logic       jump;
      logic [1:0] alu_op;
      logic       illegal;
   } ctl_t;

   logic [XLEN-1:0] regs_q [NUM_REGS];
   logic [6:0]      opcode;
   logic [4:0]      rs1_idx, rs2_idx;
   logic [XLEN-1:0] rs1_rd, rs2_rd;
   logic [XLEN-1:0] imm_dec;
   ctl_t            ctl_dec, ctl_ld;

   logic            id_valid_q, id_valid_d;
   logic [XLEN-1:0] pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic [4:0]      rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic [2:0]      funct3_q, funct3_d;
   logic            funct7b5_q, funct7b5_d;
   ctl_t            ctl_q, ctl_d;

   assign opcode  = bus.if_instr[6:0];
   assign rs1_idx = bus.if_instr[19:15];
   assign rs2_idx = bus.if_instr[24:20];

   // Register file; x0 is never written, so it stays zero after reset
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (bus.wb_en && bus.wb_rd != 5'd0) begin
         regs_q[bus.wb_rd] <= bus.wb_data;
      end
   end

`ifdef WB_BYPASS_EN
   assign rs1_rd = (rs1_idx == 5'd0) ? '0 :
                   (bus.wb_en && bus.wb_rd == rs1_idx) ? bus.wb_data : regs_q[rs1_idx];
   assign rs2_rd = (rs2_idx == 5'd0) ? '0 :
                   (bus.wb_en && bus.wb_rd == rs2_idx) ? bus.wb_data : regs_q[rs2_idx];
`else
   assign rs1_rd = (rs1_idx == 5'd0) ? '0 : regs_q[rs1_idx];
   assign rs2_rd = (rs2_idx == 5'd0) ? '0 : regs_q[rs2_idx];
`endif

   always_comb begin
      ctl_dec = '0;
      imm_dec = '0;
      case (opcode)
         7'b0110011: begin
            ctl_dec.reg_write = 1'b1;
            ctl_dec.alu_op    = 2'b10;
         end
         7'b0010011: begin
            ctl_dec.reg_write = 1'b1;
            ctl_dec.alu_src   = 1'b1;
            ctl_dec.alu_op    = 2'b11;
            imm_dec = {{(XLEN-12){bus.if_instr[31]}}, bus.if_instr[31:20]};
         end
         7'b0000011: begin
            ctl_dec.reg_write  = 1'b1;
            ctl_dec.mem_read   = 1'b1;
            ctl_dec.mem_to_reg = 1'b1;
            ctl_dec.alu_src    = 1'b1;
            imm_dec = {{(XLEN-12){bus.if_instr[31]}}, bus.if_instr[31:20]};
         end
         7'b0100011: begin
            ctl_dec.mem_write = 1'b1;
            ctl_dec.alu_src   = 1'b1;
            imm_dec = {{(XLEN-12){bus.if_instr[31]}}, bus.if_instr[31:25], bus.if_instr[11:7]};
         end
         7'b1100011: begin
            ctl_dec.branch = 1'b1;
            ctl_dec.alu_op = 2'b01;
            imm_dec = {{(XLEN-13){bus.if_instr[31]}}, bus.if_instr[31], bus.if_instr[7],
                       bus.if_instr[30:25], bus.if_instr[11:8], 1'b0};
         end
         7'b1101111: begin
            ctl_dec.reg_write = 1'b1;
            ctl_dec.jump      = 1'b1;
            imm_dec = {{(XLEN-21){bus.if_instr[31]}}, bus.if_instr[31], bus.if_instr[19:12],
                       bus.if_instr[20], bus.if_instr[30:21], 1'b0};
         end
         7'b1100111: begin
            ctl_dec.reg_write = 1'b1;
            ctl_dec.jump      = 1'b1;
            ctl_dec.alu_src   = 1'b1;
            imm_dec = {{(XLEN-12){bus.if_instr[31]}}, bus.if_instr[31:20]};
         end
         7'b0110111, 7'b0010111: begin
            ctl_dec.reg_write = 1'b1;
            ctl_dec.alu_src   = 1'b1;
            imm_dec = {{(XLEN-32){bus.if_instr[31]}}, bus.if_instr[31:12], 12'b0};
         end
         default: ctl_dec.illegal = 1'b1;
      endcase
   end

   // An invalid fetch slot must not carry any control side effects
   assign ctl_ld = bus.if_valid ? ctl_dec : '0;

   always_comb begin
      id_valid_d = id_valid_q;
      pc_d       = pc_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      rd_d       = rd_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      funct3_d   = funct3_q;
      funct7b5_d = funct7b5_q;
      ctl_d      = ctl_q;
      if (bus.flush) begin
         id_valid_d = 1'b0;
         pc_d       = '0;
         rs1_data_d = '0;
         rs2_data_d = '0;
         imm_d      = '0;
         rd_d       = '0;
         rs1_d      = '0;
         rs2_d      = '0;
         funct3_d   = '0;
         funct7b5_d = 1'b0;
         ctl_d      = '0;
      end else if (!bus.stall) begin
         id_valid_d = bus.if_valid;
         pc_d       = bus.if_pc;
         rs1_data_d = rs1_rd;
         rs2_data_d = rs2_rd;
         imm_d      = imm_dec;
         rd_d       = bus.if_instr[11:7];
         rs1_d      = rs1_idx;
         rs2_d      = rs2_idx;
         funct3_d   = bus.if_instr[14:12];
         funct7b5_d = bus.if_instr[30];
         ctl_d      = ctl_ld;
      end
   end

   // ID/EX pipeline register
   always_ff @(posedge clk) begin
      if (reset) begin
         id_valid_q <= 1'b0;
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rd_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         funct3_q   <= '0;
         funct7b5_q <= 1'b0;
         ctl_q      <= '0;
      end else begin
         id_valid_q <= id_valid_d;
         pc_q       <= pc_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         rd_q       <= rd_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         funct3_q   <= funct3_d;
         funct7b5_q <= funct7b5_d;
         ctl_q      <= ctl_d;
      end
   end

   assign bus.id_valid   = id_valid_q;
   assign bus.id_pc      = pc_q;
   assign bus.rs1_data   = rs1_data_q;
   assign bus.rs2_data   = rs2_data_q;
   assign bus.imm        = imm_q;
   assign bus.rd         = rd_q;
   assign bus.rs1        = rs1_q;
   assign bus.rs2        = rs2_q;
   assign bus.funct3     = funct3_q;
   assign bus.funct7b5   = funct7b5_q;
   assign bus.reg_write  = ctl_q.reg_write;
   assign bus.mem_read   = ctl_q.mem_read;
   assign bus.mem_write  = ctl_q.mem_write;
   assign bus.mem_to_reg = ctl_q.mem_to_reg;
   assign bus.alu_src    = ctl_q.alu_src;
   assign bus.branch     = ctl_q.branch;
   assign bus.jump       = ctl_q.jump;
   assign bus.alu_op     = ctl_q.alu_op;
   assign bus.illegal    = ctl_q.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: directed scenarios followed by random traffic,
// compared against an instruction-format reference model.
module tb_instruction_decode;

   localparam int XLEN = 64;

   typedef struct packed {
      logic            id_valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1d;
      logic [XLEN-1:0] rs2d;
      logic [XLEN-1:0] imm;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      f3;
      logic            f7;
      logic            rw, mr, mw, m2r, as, br, jp;
      logic [1:0]      aluop;
      logic            ill;
   } out_t;

   typedef enum {K_R, K_OPIMM, K_LD, K_SD, K_BR, K_JAL, K_JALR, K_U, K_BAD} kind_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instruction_decode_if #(.XLEN(XLEN)) bus ();

   instruction_decode #(.XLEN(XLEN), .NUM_REGS(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   out_t            expq[$];
   out_t            prev_exp;
   logic [XLEN-1:0] rf [32];
   int              checks = 0;
   int              errors = 0;

   function automatic kind_t kind_of(input logic [6:0] op);
      case (op)
         7'h33: return K_R;
         7'h13: return K_OPIMM;
         7'h03: return K_LD;
         7'h23: return K_SD;
         7'h63: return K_BR;
         7'h6F: return K_JAL;
         7'h67: return K_JALR;
         7'h37, 7'h17: return K_U;
         default: return K_BAD;
      endcase
   endfunction

   // Immediate as a signed integer value assembled from the format's fields
   function automatic logic [XLEN-1:0] imm_of(input logic [31:0] ins);
      longint v;
      case (kind_of(ins[6:0]))
         K_OPIMM, K_LD, K_JALR: v = longint'($signed(ins[31:20]));
         K_SD:  v = longint'($signed({ins[31:25], ins[11:7]}));
         K_BR:  v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
         K_JAL: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
         K_U:   v = longint'($signed(ins[31:12])) * 4096;
         default: v = 0;
      endcase
      return v;
   endfunction

   function automatic logic [XLEN-1:0] rd_reg(input logic [4:0] idx);
      if (idx == 0) return '0;
`ifdef WB_BYPASS_EN
      if (bus.wb_en && bus.wb_rd == idx) return bus.wb_data;
`endif
      return rf[idx];
   endfunction

   function automatic out_t load_exp();
      out_t  e;
      kind_t k;
      e = '0;
      k = kind_of(bus.if_instr[6:0]);
      e.id_valid = bus.if_valid;
      e.pc   = bus.if_pc;
      e.rs1  = bus.if_instr[19:15];
      e.rs2  = bus.if_instr[24:20];
      e.rd   = bus.if_instr[11:7];
      e.f3   = bus.if_instr[14:12];
      e.f7   = bus.if_instr[30];
      e.rs1d = rd_reg(e.rs1);
      e.rs2d = rd_reg(e.rs2);
      e.imm  = imm_of(bus.if_instr);
      if (bus.if_valid) begin
         e.rw    = k inside {K_R, K_OPIMM, K_LD, K_JAL, K_JALR, K_U};
         e.mr    = (k == K_LD);
         e.m2r   = (k == K_LD);
         e.mw    = (k == K_SD);
         e.as    = k inside {K_OPIMM, K_LD, K_SD, K_JALR, K_U};
         e.br    = (k == K_BR);
         e.jp    = k inside {K_JAL, K_JALR};
         e.aluop = (k == K_R) ? 2'b10 : (k == K_OPIMM) ? 2'b11 : (k == K_BR) ? 2'b01 : 2'b00;
         e.ill   = (k == K_BAD);
      end
      return e;
   endfunction

   // One clock: predict the outcome of this edge from the inputs it samples
   task automatic cycle();
      out_t e;
      @(posedge clk);
      if (reset) begin
         e = '0;
         for (int i = 0; i < 32; i++) rf[i] = '0;
      end else begin
         if (bus.flush)      e = '0;
         else if (bus.stall) e = prev_exp;
         else                e = load_exp();
         if (bus.wb_en && bus.wb_rd != 0) rf[bus.wb_rd] = bus.wb_data;
      end
      prev_exp = e;
      expq.push_back(e);
      #1;
   endtask

   task automatic set_in(input logic [31:0] ins, input logic v, input logic st, input logic fl,
                         input logic we, input logic [4:0] wrd, input logic [XLEN-1:0] wd);
      bus.if_instr = ins;
      bus.if_valid = v;
      bus.if_pc    = {$urandom(), $urandom()};
      bus.stall    = st;
      bus.flush    = fl;
      bus.wb_en    = we;
      bus.wb_rd    = wrd;
      bus.wb_data  = wd;
   endtask

   initial begin : monitor
      out_t act, exp;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            exp = expq.pop_front();
            act = '{bus.id_valid, bus.id_pc, bus.rs1_data, bus.rs2_data, bus.imm, bus.rd,
                    bus.rs1, bus.rs2, bus.funct3, bus.funct7b5, bus.reg_write, bus.mem_read,
                    bus.mem_write, bus.mem_to_reg, bus.alu_src, bus.branch, bus.jump,
                    bus.alu_op, bus.illegal};
            checks++;
            if (act !== exp) begin
               errors++;
               $display("FAIL idex_entry t=%0t actual=%h required=%h", $time, act, exp);
            end
         end
      end
   end

   initial begin : stimulus
      logic [31:0] r;
      logic [6:0]  ops [9];
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      prev_exp = '0;
      for (int i = 0; i < 32; i++) rf[i] = '0;

      reset = 1'b1;
      set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, '0);
      cycle();
      cycle();
      reset = 1'b0;

      set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 64'hDEAD);  cycle();
      set_in(32'h00500093, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, '0); cycle();
      set_in(32'h00028333, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, '0); cycle();
      set_in(32'hFE208EE3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, '0); cycle();
      set_in(32'h0020B823, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, '0); cycle();
      set_in(32'h00500093, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 64'd7); cycle();
      set_in(32'h00000133, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, '0); cycle();
      set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 64'h1111);  cycle();
      set_in(32'h003183B3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 64'h1234); cycle();
      set_in(32'h003183B3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, '0); cycle();
      for (int i = 0; i < 3; i++) begin
         set_in($urandom(), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, '0);
         cycle();
      end
      set_in(32'h00500093, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, '0); cycle();
      set_in(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, '0); cycle();
      set_in(32'h00500093, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, '0); cycle();

      for (int n = 0; n < 2000; n++) begin
         r = $urandom();
         if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 8)];
         set_in(r, $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                5'($urandom_range(0, 31)), {$urandom(), $urandom()});
         reset = ($urandom_range(0, 99) == 0);
         cycle();
      end
      reset = 1'b0;
      set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, '0);
      cycle();

      @(negedge clk);
      #1;
      if (expq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d required=0", expq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
